can_bus_controller: RTL and testbench
=====================================

CAN_BUS_CONTROLLER -- requirements
Module: can_bus_controller

Interface
REQ-001 SHALL have parameter ALE_CYCLES, default 2, cycles ALE held high.
REQ-002 SHALL have parameter STROBE_CYCLES, default 4, cycles RD_L/WR_L held low.
REQ-003 SHALL have parameter RECOVER_CYCLES, default 2, cycles between strobe release and DTACK.
REQ-004 SHALL have ports:
  Clk  in  1  system clock, all logic on rising edge;
  Reset_H  in  1  synchronous active-high reset;
  CAN_Enable0_H  in  1  CAN0 select, upstream decoder;
  CAN_Enable1_H  in  1  CAN1 select, upstream decoder;
  AS_L  in  1  68k address strobe;
  RW  in  1  1 = read, 0 = write;
  LDS_L  in  1  68k lower data strobe;
  Address  in  8  register index (68k A8..A1);
  CpuDataIn  in  8  68k write data D7..D0;
  CpuDataOut  out  8  read data to 68k D7..D0;
  CAN_AD_In  in  8  multiplexed bus from controller;
  CAN_AD_Out  out  8  multiplexed bus to controller;
  CAN_AD_OE_H  out  1  tristate enable for CAN_AD_Out;
  CAN_ALE_H  out  1  address latch enable;
  CAN_CS0_L, CAN_CS1_L  out  1 each  chip selects;
  CAN_RD_L, CAN_WR_L  out  1 each  read/write strobes;
  DTACK_L  out  1  68k acknowledge.

Function
REQ-005 All outputs SHALL be registered (Moore); no combinational input-to-output path.
REQ-006 FSM states SHALL be IDLE, ADDR, HOLD, STROBE, RECOVER, ACK.
REQ-007 IDLE: start on edge E where AS_L=0 and (CAN_Enable0_H or CAN_Enable1_H)=1; capture Address, RW, CpuDataIn and select (CAN0 wins if both asserted).
REQ-008 Start with LDS_L=1 (even byte only) SHALL go directly to ACK: no CAN strobes, CpuDataOut=8'hFF.
REQ-009 ADDR: CAN_AD_Out=captured Address, CAN_AD_OE_H=1, CAN_ALE_H=1 for ALE_CYCLES cycles.
REQ-010 HOLD: CAN_ALE_H=0, address still driven, 1 cycle.
REQ-011 STROBE: selected CS_L=0 for STROBE_CYCLES cycles; read: CAN_RD_L=0, CAN_AD_OE_H=0; write: CAN_WR_L=0, CAN_AD_Out=captured data, CAN_AD_OE_H=1.
REQ-012 Read: CAN_AD_In SHALL be latched into CpuDataOut on the edge leaving STROBE; CpuDataOut holds until the next latch.
REQ-013 RECOVER: CS_L, RD_L, WR_L all 1; write data and CAN_AD_OE_H held, read keeps CAN_AD_OE_H=0; RECOVER_CYCLES cycles.
REQ-014 With defaults, DTACK_L SHALL fall on edge E+9 (ALE_CYCLES+1+STROBE_CYCLES+RECOVER_CYCLES).
REQ-015 ACK: DTACK_L=0, CAN_AD_OE_H=0; on edge sampling AS_L=1, DTACK_L=1 and return to IDLE.
REQ-016 AS_L negated before ACK SHALL NOT abort the CAN cycle; it completes through RECOVER, then returns to IDLE without asserting DTACK_L.
REQ-017 Select inputs SHALL be ignored outside IDLE; a new access requires a return to IDLE.
REQ-018 CAN_CS0_L and CAN_CS1_L SHALL never be low simultaneously; CAN_RD_L and CAN_WR_L SHALL never be low simultaneously.
REQ-019 Phase counter SHALL be sized for the largest parameter and reload on each state entry.

Reset
REQ-020 Reset_H=1 at a rising edge SHALL force IDLE, counter 0, CpuDataOut=8'h00, CAN_AD_Out=8'h00, CAN_AD_OE_H=0, CAN_ALE_H=0, all _L outputs=1, regardless of state.
REQ-021 Reset mid-STROBE SHALL release all strobes on that same edge.

Configuration
REQ-022 Macro CAN_BUS_CAN1_EN defined: CAN_Enable1_H starts full CAN cycles on CAN_CS1_L.
REQ-023 CAN_BUS_CAN1_EN undefined: CAN_Enable1_H start behaves as REQ-008 (DTACK, data 8'hFF); CAN_CS1_L held 1.

Verification
REQ-024 Read CAN0, Address=8'h02, CAN_AD_In=8'h5A, LDS_L=0 -> ALE high E..E+1, CS0_L/RD_L low E+3..E+6, CpuDataOut=8'h5A, DTACK_L low at E+9.
REQ-025 Write CAN1 (macro on), Address=8'h10, CpuDataIn=8'hC3 -> CS1_L/WR_L low four cycles, CAN_AD_Out=8'hC3, OE=1 through RECOVER, CS0_L stays 1.
REQ-026 Both enables high, read -> only CAN_CS0_L asserts.
REQ-027 LDS_L=1 start -> no ALE/CS/RD/WR activity, DTACK_L low at E+1, CpuDataOut=8'hFF.
REQ-028 AS_L raised at E+4 -> strobes complete normally, DTACK_L never asserts, IDLE at E+9.
REQ-029 Reset_H pulsed at E+5 during a write -> next edge shows all _L outputs 1, OE 0, IDLE; a subsequent read completes normally.

Source files
------------

// File: rtl/can_bus_controller.sv
// can_bus_controller: 68k-to-CAN multiplexed bus bridge with ALE/CS/RD/WR sequencing and DTACK.
// Define CAN_BUS_CAN1_EN to let CAN_Enable1_H run full cycles on CAN_CS1_L.
module can_bus_controller #(
  parameter int ALE_CYCLES     = 2,
  parameter int STROBE_CYCLES  = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic       Clk,
  input  logic       Reset_H,
  input  logic       CAN_Enable0_H,
  input  logic       CAN_Enable1_H,
  input  logic       AS_L,
  input  logic       RW,
  input  logic       LDS_L,
  input  logic [7:0] Address,
  input  logic [7:0] CpuDataIn,
  output logic [7:0] CpuDataOut,
  input  logic [7:0] CAN_AD_In,
  output logic [7:0] CAN_AD_Out,
  output logic       CAN_AD_OE_H,
  output logic       CAN_ALE_H,
  output logic       CAN_CS0_L,
  output logic       CAN_CS1_L,
  output logic       CAN_RD_L,
  output logic       CAN_WR_L,
  output logic       DTACK_L
);
`ifdef CAN_BUS_CAN1_EN
  localparam bit CAN1_EN = 1'b1;
`else
  localparam bit CAN1_EN = 1'b0;
`endif
  localparam int MAXC = (ALE_CYCLES > STROBE_CYCLES) ?
                        ((ALE_CYCLES > RECOVER_CYCLES) ? ALE_CYCLES : RECOVER_CYCLES) :
                        ((STROBE_CYCLES > RECOVER_CYCLES) ? STROBE_CYCLES : RECOVER_CYCLES);
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  typedef enum logic [2:0] {IDLE, ADDR, HOLD, STROBE, RECOVER, ACK} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, load;
  logic [7:0] addr_q, data_q, addr_n, data_n;
  logic rw_q, sel_q, run_q, rw_n, sel_n, run_n, start;
  // Next-cycle capture values let the start edge already drive registered outputs.
  always_comb begin
    start = (state == IDLE) && !AS_L && (CAN_Enable0_H || CAN_Enable1_H);
    addr_n = start ? Address : addr_q;
    data_n = start ? CpuDataIn : data_q;
    rw_n = start ? RW : rw_q;
    sel_n = start ? !CAN_Enable0_H : sel_q;
    run_n = start ? (!LDS_L && (CAN_Enable0_H || CAN1_EN)) : run_q;
    state_n = state;
    case (state)
      IDLE:    state_n = start ? (run_n ? ADDR : RECOVER) : IDLE;
      ADDR:    state_n = (cnt == '0) ? HOLD : ADDR;
      HOLD:    state_n = STROBE;
      STROBE:  state_n = (cnt == '0) ? RECOVER : STROBE;
      RECOVER: state_n = (cnt == '0) ? (AS_L ? IDLE : ACK) : RECOVER;
      ACK:     state_n = AS_L ? IDLE : ACK;
      default: state_n = IDLE;
    endcase
    // Skipped accesses pass through a single RECOVER cycle on their way to ACK.
    load = (state_n == ADDR) ? CW'(ALE_CYCLES - 1) :
           (state_n == STROBE) ? CW'(STROBE_CYCLES - 1) :
           (state_n == RECOVER && run_n) ? CW'(RECOVER_CYCLES - 1) : '0;
    cnt_n = (state_n != state) ? load : (cnt != '0) ? cnt - CW'(1) : cnt;
  end
  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      data_q <= '0;
      rw_q <= 1'b0;
      sel_q <= 1'b0;
      run_q <= 1'b0;
      CpuDataOut <= 8'h00;
      CAN_AD_Out <= 8'h00;
      CAN_AD_OE_H <= 1'b0;
      CAN_ALE_H <= 1'b0;
      CAN_CS0_L <= 1'b1;
      CAN_CS1_L <= 1'b1;
      CAN_RD_L <= 1'b1;
      CAN_WR_L <= 1'b1;
      DTACK_L <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      addr_q <= addr_n;
      data_q <= data_n;
      rw_q <= rw_n;
      sel_q <= sel_n;
      run_q <= run_n;
      CAN_ALE_H <= state_n == ADDR;
      CAN_AD_OE_H <= (state_n inside {ADDR, HOLD}) ||
                     ((state_n inside {STROBE, RECOVER}) && run_n && !rw_n);
      CAN_AD_Out <= (state_n inside {ADDR, HOLD}) ? addr_n :
                    (state_n == STROBE && !rw_n) ? data_n : CAN_AD_Out;
      CAN_CS0_L <= !(state_n == STROBE && !sel_n);
      CAN_CS1_L <= !(CAN1_EN && state_n == STROBE && sel_n);
      CAN_RD_L <= !(state_n == STROBE && rw_n);
      CAN_WR_L <= !(state_n == STROBE && !rw_n);
      DTACK_L <= state_n != ACK;
      CpuDataOut <= (start && !run_n) ? 8'hFF :
                    (state == STROBE && state_n != STROBE && rw_q) ? CAN_AD_In : CpuDataOut;
    end
  end
endmodule

// File: tb/tb_can_bus_controller.sv
// tb_can_bus_controller: table-driven, reset and random accesses checked every cycle against a timing model.
module tb_can_bus_controller;
  localparam int A = 2, S = 4, R = 2;
`ifdef CAN_BUS_CAN1_EN
  localparam bit C1 = 1'b1;
`else
  localparam bit C1 = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic en0 = 1'b0, en1 = 1'b0, as_l = 1'b1, rw = 1'b1, lds_l = 1'b0;
  logic [7:0] address = '0, din = '0, dout, ad_in = '0, ad_out;
  logic oe, ale, cs0, cs1, rd, wr, dtack;
  logic [22:0] obs;
  int vectors = 0, errors = 0;
  logic [7:0] prev = 8'h00;
  typedef struct {
    bit rw; bit en0; bit en1; bit lds;
    logic [7:0] addr; logic [7:0] din; logic [7:0] adin;
    int r; logic [7:0] exp_dout; int exp_dtack;
  } vec_t;
  vec_t tbl[7];

  can_bus_controller #(.ALE_CYCLES(A), .STROBE_CYCLES(S), .RECOVER_CYCLES(R)) dut (
    .Clk(clk), .Reset_H(rst), .CAN_Enable0_H(en0), .CAN_Enable1_H(en1), .AS_L(as_l),
    .RW(rw), .LDS_L(lds_l), .Address(address), .CpuDataIn(din), .CpuDataOut(dout),
    .CAN_AD_In(ad_in), .CAN_AD_Out(ad_out), .CAN_AD_OE_H(oe), .CAN_ALE_H(ale),
    .CAN_CS0_L(cs0), .CAN_CS1_L(cs1), .CAN_RD_L(rd), .CAN_WR_L(wr), .DTACK_L(dtack));

  always #5 clk = ~clk;
  assign obs = {dout, oe ? ad_out : 8'h00, oe, ale, cs0, cs1, rd, wr, dtack};

  task automatic check(input string name, input logic [22:0] got, input logic [22:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Expected outputs k cycles after the start edge; r is the edge at which AS_L is first seen high.
  function automatic logic [22:0] model(input int k, input bit rw_i, input bit sel, input bit full,
      input logic [7:0] a, input logic [7:0] d, input logic [7:0] adin, input logic [7:0] pv, input int r);
    int dl = full ? A + S + R + 1 : 1;
    bit stb = full && k >= A + 1 && k <= A + S;
    bit al = full && k < A;
    bit o = full && (k <= A || (k < dl && !rw_i));
    logic [7:0] ad = (k <= A) ? a : d;
    logic [7:0] dv = !full ? 8'hFF : (rw_i && k >= A + S + 1) ? adin : pv;
    bit dt = k >= dl && k < r;
    return {dv, o ? ad : 8'h00, o, al, !(stb && !sel), !(stb && sel), !(stb && rw_i), !(stb && !rw_i), !dt};
  endfunction

  task automatic run_access(input bit rw_i, input bit e0, input bit e1, input bit lds,
      input logic [7:0] a, input logic [7:0] d, input logic [7:0] adin, input int r,
      output logic [7:0] dout_end, output int first_dt);
    bit full = !lds && (e0 || C1);
    bit sel = !e0;
    int dl = full ? A + S + R + 1 : 1;
    int endk = (r > dl) ? r : dl;
    rw = rw_i; en0 = e0; en1 = e1; lds_l = lds; address = a; din = d; ad_in = adin; as_l = 1'b0;
    first_dt = -1;
    @(posedge clk); #1;
    for (int k = 0; k <= endk; k++) begin
      check($sformatf("access k=%0d", k), obs, model(k, rw_i, sel, full, a, d, adin, prev, r));
      if (!dtack && first_dt < 0) first_dt = k;
      as_l = !(k + 1 < r);
      en0 = 1'($urandom);
      en1 = 1'($urandom);
      if (k < endk) begin
        @(posedge clk); #1;
      end
    end
    en0 = 1'b0; en1 = 1'b0; as_l = 1'b1;
    dout_end = dout;
    if (!full) prev = 8'hFF;
    else if (rw_i) prev = adin;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] de;
    int fd;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", obs, {8'h00, 8'h00, 7'b0011111});
    check("reset ad_out", {15'b0, ad_out}, 23'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    tbl[0] = '{1, 1, 0, 0, 8'h02, 8'h00, 8'h5A, 11, 8'h5A, 9};
    tbl[1] = '{0, 0, 1, 0, 8'h10, 8'hC3, 8'h00, 11, C1 ? 8'h5A : 8'hFF, C1 ? 9 : 1};
    tbl[2] = '{1, 1, 1, 0, 8'h21, 8'h00, 8'h3C, 11, 8'h3C, 9};
    tbl[3] = '{1, 1, 0, 1, 8'h04, 8'h00, 8'h99, 3, 8'hFF, 1};
    tbl[4] = '{1, 1, 0, 0, 8'h06, 8'h00, 8'h77, 4, 8'h77, -1};
    tbl[5] = '{0, 1, 0, 0, 8'h10, 8'hC3, 8'h00, 12, 8'h77, 9};
    tbl[6] = '{1, 1, 0, 1, 8'h08, 8'h00, 8'h00, 1, 8'hFF, -1};
    for (int i = 0; i < 7; i++) begin
      run_access(tbl[i].rw, tbl[i].en0, tbl[i].en1, tbl[i].lds, tbl[i].addr, tbl[i].din,
                 tbl[i].adin, tbl[i].r, de, fd);
      check($sformatf("tbl%0d dout", i), {15'b0, de}, {15'b0, tbl[i].exp_dout});
      check($sformatf("tbl%0d dtack", i), 23'(fd), 23'(tbl[i].exp_dtack));
    end
    // Reset sampled at E+5, in the middle of a write strobe.
    rw = 1'b0; en0 = 1'b1; lds_l = 1'b0; address = 8'h10; din = 8'hC3; as_l = 1'b0;
    @(posedge clk); #1;
    en0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid-strobe wr", {22'b0, wr}, 23'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset mid-write", obs, {8'h00, 8'h00, 7'b0011111});
    check("reset mid-write ad", {15'b0, ad_out}, 23'h0);
    rst = 1'b0; as_l = 1'b1; prev = 8'h00;
    @(posedge clk); #1;
    run_access(1, 1, 0, 0, 8'h02, 8'h00, 8'hA5, 11, de, fd);
    check("post-reset read dout", {15'b0, de}, {15'b0, 8'hA5});
    for (int i = 0; i < 40; i++) begin
      int v = $urandom_range(1, 3);
      run_access(1'($urandom), v[0], v[1], $urandom_range(0, 3) == 0, 8'($urandom),
                 8'($urandom), 8'($urandom), $urandom_range(1, 12), de, fd);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
